// File: rtl/percep_pkg.sv
// ---------------------------------------------------------------------------
// percep_pkg
// Shared constants for the perceptron memory responder: ydx/wght word and
// address widths, the position of the yd label bit inside a ydx word, and
// the number of words in a complete dataset + weight load.
// ---------------------------------------------------------------------------
package percep_pkg;

    localparam int MEM_WIDTH_YDX = 17;   // bit 16 = yd, bits 15:0 = fp attribute
    localparam int MEM_ADDR_YDX  = 7;    // 128-entry ydx memory
    localparam int MEM_ADDR_WGHT = 3;    // 8-entry wght memory
    localparam int FP_WIDTH      = 16;   // fp weight width
    localparam int YD_BIT        = 16;   // yd label position in a ydx word
    localparam int LOAD_WORDS    = 105;  // write strobes in a full load
    localparam int LOAD_CNT_W    = 7;    // width of the committed-word counter

endpackage

// File: rtl/percep_sram_1p.sv
// ---------------------------------------------------------------------------
// percep_sram_1p
// Single-port synchronous RAM, write has priority over read, registered read
// data with a one-cycle valid pulse. Contents are not reset.
// Optional feature macro: PERCEP_MEM_PARITY_EN adds one even-parity bit per
// entry (computed on write) and a sticky par_err checked as data registers.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (read regs only)
//   we          write enable (already qualified with chip select)
//   re          read enable (already qualified with chip select)
//   addr        word address
//   wdata       write data
//   rdata       registered read data, holds when idle
//   rvld        one-cycle pulse alongside new rdata
//   par_err     sticky parity error (PERCEP_MEM_PARITY_EN only)
// ---------------------------------------------------------------------------
module percep_sram_1p #(
    parameter int DW = 17,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rvld
`ifdef PERCEP_MEM_PARITY_EN
    ,
    output logic          par_err
`endif
);

    localparam int DEPTH = 1 << AW;
`ifdef PERCEP_MEM_PARITY_EN
    localparam int SW = DW + 1;
`else
    localparam int SW = DW;
`endif

    logic [SW-1:0] mem [DEPTH];
    logic [SW-1:0] wword;
    logic [SW-1:0] rword;
    logic          rd_go;
    logic [DW-1:0] rdata_p1;
    logic          vld_p1;

`ifdef PERCEP_MEM_PARITY_EN
    // Stored parity bit makes the XOR over the whole entry zero.
    assign wword = {^wdata, wdata};
`else
    assign wword = wdata;
`endif

    assign rword = mem[addr];
    assign rd_go = re & ~we;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wword;
        end
    end

    // stage p1: registered read data and its valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= rd_go;
            if (rd_go) begin
                rdata_p1 <= rword[DW-1:0];
            end
        end
    end

`ifdef PERCEP_MEM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (rd_go && (^rword)) begin
            par_err <= 1'b1;
        end
    end
`endif

    assign rdata = rdata_p1;
    assign rvld  = vld_p1;

endmodule

// File: rtl/percep_mem_resp.sv
// ---------------------------------------------------------------------------
// percep_mem_resp
// Memory-side responder for the perceptron controller. Host words enter a
// small valid/ready FIFO; each ydx write strobe pops one word into the ydx
// memory (and, when the wght strobe is also active, its low 16 bits into the
// wght memory). Reads return registered data one cycle after the strobe.
// Optional feature macro: PERCEP_MEM_PARITY_EN (per-entry parity, par_err).
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   host_valid/host_data/host_ready  host preload handshake
//   mem_cs/we/oe_ydx, d_addr_ydx   ydx port from the controller
//   mem_cs/we/oe_wght, d_addr_wght wght port from the controller
//   rd_ydx, rd_valid_ydx           ydx read data and valid pulse
//   rd_wght, rd_valid_wght         wght read data and valid pulse
//   load_cnt                       words committed since reset (sat. 127)
//   underrun                       sticky: write strobe saw an empty FIFO
//   par_err                        sticky parity error (macro only)
// ---------------------------------------------------------------------------
module percep_mem_resp
    import percep_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_valid,
    input  logic [MEM_WIDTH_YDX-1:0] host_data,
    output logic                     host_ready,
    input  logic                     mem_cs_ydx,
    input  logic                     mem_we_ydx,
    input  logic                     mem_oe_ydx,
    input  logic [MEM_ADDR_YDX-1:0]  d_addr_ydx,
    input  logic                     mem_cs_wght,
    input  logic                     mem_we_wght,
    input  logic                     mem_oe_wght,
    input  logic [MEM_ADDR_WGHT-1:0] d_addr_wght,
    output logic [MEM_WIDTH_YDX-1:0] rd_ydx,
    output logic                     rd_valid_ydx,
    output logic [FP_WIDTH-1:0]      rd_wght,
    output logic                     rd_valid_wght,
    output logic [LOAD_CNT_W-1:0]    load_cnt,
    output logic                     underrun
`ifdef PERCEP_MEM_PARITY_EN
    ,
    output logic                     par_err
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [MEM_WIDTH_YDX-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [PW:0]              fifo_cnt;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     wr_ydx;
    logic                     wr_wght;
    logic                     re_ydx;
    logic                     re_wght;
    logic [MEM_WIDTH_YDX-1:0] wr_word;

    function automatic logic [LOAD_CNT_W-1:0] sat_inc(input logic [LOAD_CNT_W-1:0] v);
        return (v == {LOAD_CNT_W{1'b1}}) ? v : v + LOAD_CNT_W'(1);
    endfunction

    // Occupancy is registered, so ready and empty never see this cycle's pop.
    // A push into an empty FIFO therefore cannot be forwarded to a same-cycle
    // write strobe: that strobe underruns and the pushed word waits.
    assign fifo_empty = (fifo_cnt == '0);
    assign host_ready = (fifo_cnt != CNT_FULL);
    assign push       = host_valid & host_ready;
    assign wr_ydx     = mem_cs_ydx & mem_we_ydx;
    assign pop        = wr_ydx & ~fifo_empty;
    assign wr_word    = fifo_empty ? '0 : fifo_q[rd_ptr];

    assign wr_wght = wr_ydx & mem_cs_wght & mem_we_wght;
    assign re_ydx  = mem_cs_ydx & mem_oe_ydx & ~mem_we_ydx;
    assign re_wght = mem_cs_wght & mem_oe_wght & ~mem_we_wght;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= host_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            load_cnt <= '0;
            underrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (wr_ydx) begin
                load_cnt <= sat_inc(load_cnt);
                if (fifo_empty) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

`ifdef PERCEP_MEM_PARITY_EN
    logic perr_ydx;
    logic perr_wght;
    assign par_err = perr_ydx | perr_wght;
`endif

    percep_sram_1p #(
        .DW (MEM_WIDTH_YDX),
        .AW (MEM_ADDR_YDX)
    ) u_ydx (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_ydx),
        .re      (re_ydx),
        .addr    (d_addr_ydx),
        .wdata   (wr_word),
        .rdata   (rd_ydx),
        .rvld    (rd_valid_ydx)
`ifdef PERCEP_MEM_PARITY_EN
        ,
        .par_err (perr_ydx)
`endif
    );

    percep_sram_1p #(
        .DW (FP_WIDTH),
        .AW (MEM_ADDR_WGHT)
    ) u_wght (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_wght),
        .re      (re_wght),
        .addr    (d_addr_wght),
        .wdata   (wr_word[FP_WIDTH-1:0]),
        .rdata   (rd_wght),
        .rvld    (rd_valid_wght)
`ifdef PERCEP_MEM_PARITY_EN
        ,
        .par_err (perr_wght)
`endif
    );

endmodule

// File: tb/tb_percep_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_percep_mem_resp
// Directed bench for percep_mem_resp: reset values, full 105-word load,
// read latency, write-wins, chip-select gating, underrun, FIFO full/ready,
// load_cnt saturation, asynchronous reset mid-load and (with
// PERCEP_MEM_PARITY_EN) parity error detection.
// ---------------------------------------------------------------------------
module tb_percep_mem_resp;
    import percep_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     host_valid;
    logic [MEM_WIDTH_YDX-1:0] host_data;
    logic                     host_ready;
    logic                     mem_cs_ydx, mem_we_ydx, mem_oe_ydx;
    logic [MEM_ADDR_YDX-1:0]  d_addr_ydx;
    logic                     mem_cs_wght, mem_we_wght, mem_oe_wght;
    logic [MEM_ADDR_WGHT-1:0] d_addr_wght;
    logic [MEM_WIDTH_YDX-1:0] rd_ydx;
    logic                     rd_valid_ydx;
    logic [FP_WIDTH-1:0]      rd_wght;
    logic                     rd_valid_wght;
    logic [LOAD_CNT_W-1:0]    load_cnt;
    logic                     underrun;
`ifdef PERCEP_MEM_PARITY_EN
    logic                     par_err;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    percep_mem_resp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_valid    (host_valid),
        .host_data     (host_data),
        .host_ready    (host_ready),
        .mem_cs_ydx    (mem_cs_ydx),
        .mem_we_ydx    (mem_we_ydx),
        .mem_oe_ydx    (mem_oe_ydx),
        .d_addr_ydx    (d_addr_ydx),
        .mem_cs_wght   (mem_cs_wght),
        .mem_we_wght   (mem_we_wght),
        .mem_oe_wght   (mem_oe_wght),
        .d_addr_wght   (d_addr_wght),
        .rd_ydx        (rd_ydx),
        .rd_valid_ydx  (rd_valid_ydx),
        .rd_wght       (rd_wght),
        .rd_valid_wght (rd_valid_wght),
        .load_cnt      (load_cnt),
        .underrun      (underrun)
`ifdef PERCEP_MEM_PARITY_EN
        ,
        .par_err       (par_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        host_valid  = 1'b0;
        mem_cs_ydx  = 1'b0;
        mem_we_ydx  = 1'b0;
        mem_oe_ydx  = 1'b0;
        mem_cs_wght = 1'b0;
        mem_we_wght = 1'b0;
        mem_oe_wght = 1'b0;
    endtask

    task automatic wr_strobe(input int a);
        mem_cs_ydx = 1'b1;
        mem_we_ydx = 1'b1;
        d_addr_ydx = 7'(a);
        tick();
        mem_cs_ydx = 1'b0;
        mem_we_ydx = 1'b0;
    endtask

    task automatic rd_ydx_chk(input string tag, input int a, input logic [31:0] exp);
        mem_cs_ydx = 1'b1;
        mem_oe_ydx = 1'b1;
        mem_we_ydx = 1'b0;
        d_addr_ydx = 7'(a);
        tick();
        chk({tag, "_vld"}, 32'(rd_valid_ydx), 32'd1);
        chk(tag, 32'(rd_ydx), exp);
        mem_cs_ydx = 1'b0;
        mem_oe_ydx = 1'b0;
        tick();
        chk({tag, "_vld_off"}, 32'(rd_valid_ydx), 32'd0);
        chk({tag, "_hold"}, 32'(rd_ydx), exp);
    endtask

    task automatic rd_wght_chk(input string tag, input int a, input logic [31:0] exp);
        mem_cs_wght = 1'b1;
        mem_oe_wght = 1'b1;
        mem_we_wght = 1'b0;
        d_addr_wght = 3'(a);
        tick();
        chk({tag, "_vld"}, 32'(rd_valid_wght), 32'd1);
        chk(tag, 32'(rd_wght), exp);
        mem_cs_wght = 1'b0;
        mem_oe_wght = 1'b0;
        tick();
        chk({tag, "_vld_off"}, 32'(rd_valid_wght), 32'd0);
    endtask

    initial begin
        int p;
        idle();
        host_data   = '0;
        d_addr_ydx  = '0;
        d_addr_wght = '0;
        rst_n       = 1'b0;
        tick();
        tick();

        // reset values
        chk("rst_host_ready", 32'(host_ready), 32'd1);
        chk("rst_rd_ydx", 32'(rd_ydx), 32'd0);
        chk("rst_rd_wght", 32'(rd_wght), 32'd0);
        chk("rst_vld_ydx", 32'(rd_valid_ydx), 32'd0);
        chk("rst_vld_wght", 32'(rd_valid_wght), 32'd0);
        chk("rst_load_cnt", 32'(load_cnt), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
`ifdef PERCEP_MEM_PARITY_EN
        chk("rst_par_err", 32'(par_err), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // full load: prefill 3, then 105 strobes with pushes sustained
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1;
            host_data  = 17'(i);
            tick();
        end
        p = 3;
        for (int w = 0; w < 105; w++) begin
            host_valid  = (p < 105);
            host_data   = 17'(p);
            mem_cs_ydx  = 1'b1;
            mem_we_ydx  = 1'b1;
            d_addr_ydx  = 7'(w);
            mem_cs_wght = (w >= 100);
            mem_we_wght = (w >= 100);
            d_addr_wght = 3'(w - 100);
            tick();
            if (p < 105) p++;
        end
        idle();
        chk("load_cnt_105", 32'(load_cnt), 32'd105);
        chk("load_underrun", 32'(underrun), 32'd0);
        rd_ydx_chk("rd_ydx3", 3, 32'h00003);
        rd_ydx_chk("rd_ydx0", 0, 32'h00000);
        rd_ydx_chk("rd_ydx104", 104, 32'h00068);
        for (int k = 0; k < 5; k++) begin
            rd_wght_chk($sformatf("rd_wght%0d", k), k, 32'h64 + 32'(k));
        end

        // write with oe also high: write wins, no read pulse
        host_valid = 1'b1;
        host_data  = 17'h1ABCD;
        tick();
        host_valid  = 1'b0;
        mem_cs_ydx  = 1'b1;
        mem_we_ydx  = 1'b1;
        mem_oe_ydx  = 1'b1;
        d_addr_ydx  = 7'd10;
        mem_cs_wght = 1'b1;
        mem_we_wght = 1'b1;
        mem_oe_wght = 1'b1;
        d_addr_wght = 3'd6;
        tick();
        idle();
        chk("we_oe_no_vld_ydx", 32'(rd_valid_ydx), 32'd0);
        chk("we_oe_no_vld_wght", 32'(rd_valid_wght), 32'd0);
        rd_ydx_chk("rd_ydx10_yd", 10, 32'h1ABCD);
        rd_wght_chk("rd_wght6", 6, 32'hABCD);

        // chip select low: we/oe ignored
        mem_we_ydx = 1'b1;
        mem_oe_ydx = 1'b1;
        tick();
        idle();
        chk("cs_low_no_vld", 32'(rd_valid_ydx), 32'd0);
        chk("cs_low_cnt", 32'(load_cnt), 32'd106);
        chk("cs_low_underrun", 32'(underrun), 32'd0);

        // underrun on empty FIFO, sticky across a push
        wr_strobe(20);
        chk("underrun_set", 32'(underrun), 32'd1);
        chk("underrun_cnt", 32'(load_cnt), 32'd107);
        rd_ydx_chk("rd_ydx20_zero", 20, 32'h0);
        host_valid = 1'b1;
        host_data  = 17'h00055;
        tick();
        host_valid = 1'b0;
        chk("underrun_held", 32'(underrun), 32'd1);
        wr_strobe(21);
        // push into empty with same-cycle strobe: zero written, word kept
        host_valid = 1'b1;
        host_data  = 17'h00077;
        wr_strobe(22);
        host_valid = 1'b0;
        wr_strobe(23);
        rd_ydx_chk("rd_ydx21", 21, 32'h00055);
        rd_ydx_chk("rd_ydx22_zero", 22, 32'h0);
        rd_ydx_chk("rd_ydx23_kept", 23, 32'h00077);
        chk("cnt_110", 32'(load_cnt), 32'd110);

        // FIFO fill: ready drops after 4 pushes
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1;
            host_data  = 17'h100 + 17'(i);
            tick();
            chk($sformatf("fill_ready%0d", i), 32'(host_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        host_valid = 1'b0;
        wr_strobe(30);
        chk("pop_ready", 32'(host_ready), 32'd1);
        host_valid = 1'b1;
        host_data  = 17'h200;
        wr_strobe(31);
        chk("push_pop_ready", 32'(host_ready), 32'd1);
        host_data = 17'h201;
        tick();
        host_valid = 1'b0;
        chk("refull_ready", 32'(host_ready), 32'd0);
        rd_ydx_chk("rd_ydx30", 30, 32'h100);
        rd_ydx_chk("rd_ydx31", 31, 32'h101);
        chk("cnt_112", 32'(load_cnt), 32'd112);

        // load_cnt saturation at 127
        for (int i = 0; i < 14; i++) wr_strobe(40);
        chk("cnt_126", 32'(load_cnt), 32'd126);
        for (int i = 0; i < 6; i++) wr_strobe(40);
        chk("cnt_sat_127", 32'(load_cnt), 32'd127);

        // asynchronous reset in the middle of a load
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1;
            host_data  = 17'h300 + 17'(i);
            tick();
        end
        p = 3;
        for (int w = 0; w < 50; w++) begin
            host_valid = 1'b1;
            host_data  = 17'h300 + 17'(p);
            mem_cs_ydx = 1'b1;
            mem_we_ydx = 1'b1;
            d_addr_ydx = 7'(w);
            tick();
            p++;
        end
        idle();
        chk("mid_cnt_50", 32'(load_cnt), 32'd50);
        mem_cs_ydx = 1'b1;
        mem_oe_ydx = 1'b1;
        d_addr_ydx = 7'd5;
        tick();
        idle();
        chk("mid_rd_vld", 32'(rd_valid_ydx), 32'd1);
        chk("mid_rd_data", 32'(rd_ydx), 32'h305);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_load_cnt", 32'(load_cnt), 32'd0);
        chk("arst_ready", 32'(host_ready), 32'd1);
        chk("arst_vld_ydx", 32'(rd_valid_ydx), 32'd0);
        chk("arst_vld_wght", 32'(rd_valid_wght), 32'd0);
        chk("arst_rd_ydx", 32'(rd_ydx), 32'd0);
        chk("arst_underrun", 32'(underrun), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        // FIFO held 3 words before reset; it must now be empty
        wr_strobe(60);
        chk("post_rst_underrun", 32'(underrun), 32'd1);
        chk("post_rst_cnt", 32'(load_cnt), 32'd1);

`ifdef PERCEP_MEM_PARITY_EN
        chk("par_clean", 32'(par_err), 32'd0);
        dut.u_ydx.mem[3] = dut.u_ydx.mem[3] ^ 18'h00001;
        mem_cs_ydx = 1'b1;
        mem_oe_ydx = 1'b1;
        d_addr_ydx = 7'd3;
        tick();
        idle();
        chk("par_rd_data", 32'(rd_ydx), 32'h302);
        chk("par_err_set", 32'(par_err), 32'd1);
        tick();
        chk("par_err_sticky", 32'(par_err), 32'd1);
`else
        rd_ydx_chk("rd_ydx3_reload", 3, 32'h303);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
